// File: rtl/nios_rng_pkg.sv
// Shared constants for the random-number peripheral: register map,
// control bit positions and the Galois LFSR feedback mask.
package nios_rng_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_SEED = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_DRAW = 2'd3;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_AUTO = 1;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

endpackage

// File: rtl/nios_system_random_gen_if.sv
// Avalon-MM slave bus bundle for the random-number peripheral.
interface nios_system_random_gen_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios_system_random_gen_lfsr.sv
// Free-running 32-bit Galois LFSR with synchronous load; load wins over step.
module random_lfsr32
  import nios_rng_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2017
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED_DEFAULT;
    end else if (load) begin
      r_state <= load_val;
    end else if (en) begin
      r_state <= r_state[0] ? ((r_state >> 1) ^ LFSR_MASK) : (r_state >> 1);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/nios_system_random_gen.sv
// Random-number peripheral: LFSR with rejection sampling into [0, RANGE),
// draw register feeding out_port, and a legacy manual PIO mode.
module nios_system_random_gen
  import nios_rng_pkg::*;
#(
  parameter int          OUT_WIDTH    = 3,
  parameter int          RANGE        = 7,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2017
) (
  input  logic                       clk,
  input  logic                       reset,
  nios_system_random_gen_if.slave    bus,
  output logic [OUT_WIDTH-1:0]       out_port
);

  // 17 bits holds RANGE up to 2**16 so the full-range case never rejects.
  localparam logic [16:0] RANGE_L = 17'(RANGE);

  logic                 w_wr;
  logic                 w_rd;
  logic                 w_draw;
  logic                 w_seed_wr;
  logic [31:0]          w_seed_val;
  logic [31:0]          w_lfsr;
  logic [OUT_WIDTH-1:0] w_cand;
  logic                 w_accept;
  logic [31:0]          w_readdata;

  logic                 r_run;
  logic                 r_auto;
  logic [OUT_WIDTH-1:0] r_data_out;
  logic [OUT_WIDTH-1:0] r_sample;
  logic [OUT_WIDTH-1:0] r_held;
  logic [15:0]          r_draw_count;

  assign w_wr       = bus.chipselect & ~bus.write_n;
  assign w_rd       = bus.chipselect & ~bus.read_n;
  assign w_draw     = (w_wr | w_rd) & (bus.address == ADDR_DRAW);
  assign w_seed_wr  = w_wr & (bus.address == ADDR_SEED);
  assign w_seed_val = (bus.writedata == 32'd0) ? SEED_DEFAULT : bus.writedata;

  random_lfsr32 #(
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .en       (r_run),
    .load     (w_seed_wr),
    .load_val (w_seed_val),
    .state    (w_lfsr)
  );

  assign w_cand   = w_lfsr[OUT_WIDTH-1:0];
  assign w_accept = r_run & ({{(17-OUT_WIDTH){1'b0}}, w_cand} < RANGE_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run        <= 1'b1;
      r_auto       <= 1'b0;
      r_data_out   <= '0;
      r_sample     <= '0;
      r_held       <= '0;
      r_draw_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_sample <= w_cand;
      end
      if (w_wr && bus.address == ADDR_DATA) begin
        r_data_out <= bus.writedata[OUT_WIDTH-1:0];
      end
      if (w_wr && bus.address == ADDR_CTRL) begin
        r_run  <= bus.writedata[CTRL_RUN];
        r_auto <= bus.writedata[CTRL_AUTO];
      end
      // Draw captures the sample as it stood before this cycle's update.
      if (w_draw) begin
        r_held       <= r_sample;
        r_draw_count <= r_draw_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_readdata = 32'd0;
    case (bus.address)
      ADDR_DATA: w_readdata = {{(32-OUT_WIDTH){1'b0}}, out_port};
      ADDR_SEED: w_readdata = w_lfsr;
      ADDR_CTRL: w_readdata = {r_draw_count, 14'd0, r_auto, r_run};
      ADDR_DRAW: w_readdata = {{(32-OUT_WIDTH){1'b0}}, r_sample};
      default:   w_readdata = 32'd0;
    endcase
  end

  assign bus.readdata = w_readdata;
  assign out_port     = r_auto ? r_held : r_data_out;

endmodule
